// File: rtl/op_sequencer.sv
// Iterating operation-class sequencer: classifies a/b, pulses the class enable, awaits the
// datapath ack (with optional timeout) and counts ITERS iterations. `OP_STATS_EN adds per-class entry counters.
module op_sequencer #(
  parameter int WIDTH       = 4,
  parameter int ITERS       = 8,
  parameter int ACK_TIMEOUT = 15,
  localparam int CNT_W      = $clog2(ITERS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_ack,
  output logic             done,
  output logic             busy,
  output logic             sumen,
  output logic             multien,
  output logic             consten,
  output logic             erroren,
  output logic             counten,
  output logic [CNT_W-1:0] iter_count,
  output logic             timeout_flag
`ifdef OP_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_sum,
  output logic [CNT_W-1:0] stat_mul,
  output logic [CNT_W-1:0] stat_const,
  output logic [CNT_W-1:0] stat_err
`endif
);

  localparam int WAIT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONTROL,
    S_EXEC,
    S_COUNT
  } state_t;

  // Encoding order matches the bit order of en_vec below.
  typedef enum logic [1:0] {
    OP_SUM,
    OP_MUL,
    OP_CONST,
    OP_ERR
  } op_t;

  state_t             state_q, state_d;
  op_t                op_sel_q, op_sel_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic               tflag_q, tflag_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic [CNT_W-1:0]   iter_inc;
  logic [WAIT_W-1:0]  wait_inc;
  logic [3:0]         en_vec;

  function automatic op_t classify(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (x == '0 || y == '0) begin
      return OP_ERR;
    end else if (x < y) begin
      return OP_MUL;
    end else if (x == y) begin
      return OP_CONST;
    end else begin
      return OP_SUM;
    end
  endfunction

  assign iter_inc = iter_q + 1'b1;
  assign wait_inc = wait_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    op_sel_d = op_sel_q;
    iter_d   = iter_q;
    tflag_d  = tflag_q;
    wait_d   = wait_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          iter_d  = '0;
          tflag_d = 1'b0;
          state_d = S_CONTROL;
        end
      end
      S_CONTROL: begin
        op_sel_d = classify(a, b);
        wait_d   = '0;
        state_d  = abort ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        // abort outranks both the ack and the timeout
        if (abort) begin
          state_d = S_IDLE;
        end else if (op_sel_q == OP_ERR || op_ack) begin
          state_d = S_COUNT;
        end else if (ACK_TIMEOUT > 0) begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_W'(ACK_TIMEOUT)) begin
            tflag_d = 1'b1;
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          iter_d  = iter_inc;
          state_d = (iter_inc >= CNT_W'(ITERS)) ? S_IDLE : S_CONTROL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_sel_q <= OP_SUM;
      iter_q   <= '0;
      tflag_q  <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_sel_q <= op_sel_d;
      iter_q   <= iter_d;
      tflag_q  <= tflag_d;
      wait_q   <= wait_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_en
    assign en_vec[gi] = (state_q == S_EXEC) && (op_sel_q == op_t'(gi));
  end

  assign sumen        = en_vec[OP_SUM];
  assign multien      = en_vec[OP_MUL];
  assign consten      = en_vec[OP_CONST];
  assign erroren      = en_vec[OP_ERR];
  assign done         = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign counten      = (state_q == S_COUNT);
  assign iter_count   = iter_q;
  assign timeout_flag = tflag_q;

`ifdef OP_STATS_EN
  logic [4*CNT_W-1:0] stat_vec;

  // One counter per class, bumped on each CONTROL->EXEC transition of that class.
  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_IDLE && start) begin
        cnt_d = '0;
      end else if (state_q == S_CONTROL && !abort && op_sel_d == op_t'(gi)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stat_vec[gi*CNT_W +: CNT_W] = cnt_q;
  end

  assign stat_sum   = stat_vec[0*CNT_W +: CNT_W];
  assign stat_mul   = stat_vec[1*CNT_W +: CNT_W];
  assign stat_const = stat_vec[2*CNT_W +: CNT_W];
  assign stat_err   = stat_vec[3*CNT_W +: CNT_W];
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: expected classes are queued as operands are applied
// and popped when an enable rises; each task checks run-level results inline.
module tb_op_sequencer;

  localparam int WIDTH       = 4;
  localparam int ITERS       = 8;
  localparam int ACK_TIMEOUT = 15;
  localparam int CNT_W       = $clog2(ITERS + 1);

  localparam int C_NONE  = 0;
  localparam int C_SUM   = 1;
  localparam int C_MUL   = 2;
  localparam int C_CONST = 3;
  localparam int C_ERR   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             op_ack = 1'b0;
  logic             done, busy, sumen, multien, consten, erroren, counten, timeout_flag;
  logic [CNT_W-1:0] iter_count;
`ifdef OP_STATS_EN
  logic [CNT_W-1:0] stat_sum, stat_mul, stat_const, stat_err;
`endif

  op_sequencer #(.WIDTH(WIDTH), .ITERS(ITERS), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .a(a), .b(b), .op_ack(op_ack),
    .done(done), .busy(busy), .sumen(sumen), .multien(multien), .consten(consten),
    .erroren(erroren), .counten(counten), .iter_count(iter_count), .timeout_flag(timeout_flag)
`ifdef OP_STATS_EN
    , .stat_sum(stat_sum), .stat_mul(stat_mul), .stat_const(stat_const), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sb[$];
  int txn = 0;
  bit mon_en = 1'b0;
  logic prev_any = 1'b0;

  logic [WIDTH-1:0] seq_a [ITERS];
  logic [WIDTH-1:0] seq_b [ITERS];
  int seq_idx;

  int poke_start_at = -1;
  int abort_after   = -1;
  int reset_after   = -1;
  int r_cycles, r_cnt, r_fire_cycle;
  int r_en [5];

  function automatic int exp_class(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (x == 0 || y == 0) return C_ERR;
    if (x < y) return C_MUL;
    if (x == y) return C_CONST;
    return C_SUM;
  endfunction

  function automatic int obs_class();
    if (sumen) return C_SUM;
    if (multien) return C_MUL;
    if (consten) return C_CONST;
    if (erroren) return C_ERR;
    return C_NONE;
  endfunction

  // Scoreboard monitor: one-hot enables, busy/done complement, class at each EXEC entry.
  always @(negedge clk) begin
    automatic logic any = sumen | multien | consten | erroren;
    automatic int e;
    if (mon_en) begin
      checks++;
      if ($countones({sumen, multien, consten, erroren}) > 1 || busy !== ~done) begin
        errors++;
        $display("FAIL onehot_busy: en=%b busy=%b done=%b", {sumen, multien, consten, erroren}, busy, done);
      end
      if (any && !prev_any) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: got class %0d, nothing expected", obs_class());
        end else begin
          e = sb.pop_front();
          txn++;
          $display("txn %0d: exec class=%0d expected=%0d", txn, obs_class(), e);
          if (obs_class() !== e) begin
            errors++;
            $display("FAIL exec_class: got %0d expected %0d", obs_class(), e);
          end
        end
      end
    end
    prev_any <= any;
  end

  task automatic set_seq(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb);
    for (int i = 0; i < ITERS; i++) begin
      seq_a[i] = xa;
      seq_b[i] = xb;
    end
  endtask

  task automatic kick();
    @(negedge clk);
    seq_idx = 0;
    a = seq_a[0];
    b = seq_b[0];
    sb.push_back(exp_class(a, b));
    start = 1'b1;
  endtask

  // Advances the run until done, applying next operands at each counten and
  // optionally injecting start/abort/reset at scheduled points.
  task automatic run_collect(input int limit);
    bit fired = 1'b0;
    r_cycles = 0;
    r_cnt = 0;
    r_fire_cycle = -1;
    for (int i = 0; i < 5; i++) r_en[i] = 0;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    r_cycles = 1;
    while (busy && r_cycles < limit) begin
      start = (r_cycles == poke_start_at);
      r_en[obs_class()]++;
      if (!fired && abort_after >= 0 && r_cnt == abort_after && obs_class() != C_NONE) begin
        abort = 1'b1;
        op_ack = 1'b1;
        fired = 1'b1;
        r_fire_cycle = r_cycles;
      end
      if (counten) begin
        r_cnt++;
        if (!fired && reset_after >= 0 && r_cnt == reset_after) begin
          reset = 1'b1;
          fired = 1'b1;
          r_fire_cycle = r_cycles;
        end else if (seq_idx < ITERS - 1) begin
          seq_idx++;
          a = seq_a[seq_idx];
          b = seq_b[seq_idx];
          sb.push_back(exp_class(a, b));
        end
      end
      @(negedge clk);
      r_cycles++;
    end
    start = 1'b0;
    checks++;
    if (r_cycles >= limit) begin
      errors++;
      $display("FAIL run_bound: still busy after %0d cycles", r_cycles);
    end
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({done, busy, sumen, multien, consten, erroren, counten} !== 7'b1000000 ||
        iter_count !== '0 || timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: done/busy/en/cnt=%b iter=%0d tflag=%b required 1000000 0 0",
               {done, busy, sumen, multien, consten, erroren, counten}, iter_count, timeout_flag);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({done, busy, sumen, multien, consten, erroren, counten} !== 7'b1000000 || iter_count !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_hold: outputs changed in IDLE with start=0");
    end
    mon_en = 1'b1;
  endtask

  task automatic test_mul_run();
    set_seq(4'd3, 4'd9);
    op_ack = 1'b1;
    poke_start_at = 10;
    kick();
    run_collect(200);
    poke_start_at = -1;
    checks++;
    if (r_cycles - 1 !== 3 * ITERS || r_cnt !== ITERS || r_en[C_MUL] !== ITERS) begin
      errors++;
      $display("FAIL mul_run: span=%0d counten=%0d multien=%0d required %0d %0d %0d",
               r_cycles - 1, r_cnt, r_en[C_MUL], 3 * ITERS, ITERS, ITERS);
    end
    checks++;
    if (iter_count !== CNT_W'(ITERS) || timeout_flag !== 1'b0 || done !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL mul_end: iter=%0d tflag=%b done=%b sb=%0d required %0d 0 1 0",
               iter_count, timeout_flag, done, sb.size(), ITERS);
    end
`ifdef OP_STATS_EN
    checks++;
    if (stat_mul !== CNT_W'(ITERS) || stat_sum !== '0 || stat_const !== '0 || stat_err !== '0) begin
      errors++;
      $display("FAIL mul_stats: mul=%0d sum=%0d const=%0d err=%0d required %0d 0 0 0",
               stat_mul, stat_sum, stat_const, stat_err, ITERS);
    end
`endif
  endtask

  task automatic test_class_mix();
    logic [WIDTH-1:0] ta [8] = '{4'd0, 4'd6, 4'd9, 4'd3, 4'd5, 4'd6, 4'd9, 4'd1};
    logic [WIDTH-1:0] tb [8] = '{4'd5, 4'd6, 4'd2, 4'd9, 4'd0, 4'd6, 4'd2, 4'd1};
    for (int i = 0; i < ITERS; i++) begin
      seq_a[i] = ta[i];
      seq_b[i] = tb[i];
    end
    op_ack = 1'b1;
    kick();
    run_collect(200);
    checks++;
    if (r_en[C_ERR] !== 2 || r_en[C_CONST] !== 3 || r_en[C_SUM] !== 2 || r_en[C_MUL] !== 1) begin
      errors++;
      $display("FAIL mix_cycles: err=%0d const=%0d sum=%0d mul=%0d required 2 3 2 1",
               r_en[C_ERR], r_en[C_CONST], r_en[C_SUM], r_en[C_MUL]);
    end
    checks++;
    if (r_cycles - 1 !== 3 * ITERS || iter_count !== CNT_W'(ITERS) || sb.size() != 0) begin
      errors++;
      $display("FAIL mix_end: span=%0d iter=%0d sb=%0d required %0d %0d 0",
               r_cycles - 1, iter_count, sb.size(), 3 * ITERS, ITERS);
    end
`ifdef OP_STATS_EN
    checks++;
    if (stat_err !== 2 || stat_const !== 3 || stat_sum !== 2 || stat_mul !== 1) begin
      errors++;
      $display("FAIL mix_stats: err=%0d const=%0d sum=%0d mul=%0d required 2 3 2 1",
               stat_err, stat_const, stat_sum, stat_mul);
    end
`endif
  endtask

  task automatic test_timeout();
    set_seq(4'd9, 4'd2);
    op_ack = 1'b0;
    kick();
    run_collect(400);
    checks++;
    if (r_en[C_SUM] !== ACK_TIMEOUT * ITERS || r_cnt !== ITERS || r_cycles - 1 !== (ACK_TIMEOUT + 2) * ITERS) begin
      errors++;
      $display("FAIL timeout_run: sumen=%0d counten=%0d span=%0d required %0d %0d %0d",
               r_en[C_SUM], r_cnt, r_cycles - 1, ACK_TIMEOUT * ITERS, ITERS, (ACK_TIMEOUT + 2) * ITERS);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_flag !== 1'b1 || iter_count !== CNT_W'(ITERS)) begin
      errors++;
      $display("FAIL timeout_sticky: tflag=%b iter=%0d required 1 %0d", timeout_flag, iter_count, ITERS);
    end
    op_ack = 1'b1;
    set_seq(4'd7, 4'd7);
    kick();
    run_collect(200);
    checks++;
    if (timeout_flag !== 1'b0 || r_en[C_CONST] !== ITERS || sb.size() != 0) begin
      errors++;
      $display("FAIL timeout_clear: tflag=%b consten=%0d sb=%0d required 0 %0d 0",
               timeout_flag, r_en[C_CONST], sb.size(), ITERS);
    end
  endtask

  task automatic test_abort();
    set_seq(4'd3, 4'd9);
    op_ack = 1'b1;
    abort_after = 2;
    kick();
    run_collect(200);
    abort_after = -1;
    checks++;
    if (r_cycles !== r_fire_cycle + 1 || iter_count !== 2 || r_cnt !== 2 ||
        {sumen, multien, consten, erroren, counten} !== 5'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL abort: exit=%0d fire=%0d iter=%0d cnt=%0d en=%b done=%b required exit=fire+1 2 2 0 1",
               r_cycles, r_fire_cycle, iter_count, r_cnt, {sumen, multien, consten, erroren, counten}, done);
    end
    abort = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL abort_sb: %0d leftover expected entries, required 0", sb.size());
    end
    kick();
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (iter_count !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: iter=%0d busy=%b required 0 1", iter_count, busy);
    end
    run_collect(200);
    checks++;
    if (iter_count !== CNT_W'(ITERS) || r_cnt !== ITERS) begin
      errors++;
      $display("FAIL restart_run: iter=%0d counten=%0d required %0d %0d", iter_count, r_cnt, ITERS, ITERS);
    end
  endtask

  task automatic test_start_abort();
    set_seq(4'd9, 4'd2);
    op_ack = 1'b1;
    kick();
    abort = 1'b1;
    run_collect(200);
    checks++;
    if (r_cycles - 1 !== 3 * ITERS || iter_count !== CNT_W'(ITERS) || r_en[C_SUM] !== ITERS) begin
      errors++;
      $display("FAIL start_abort: span=%0d iter=%0d sumen=%0d required %0d %0d %0d",
               r_cycles - 1, iter_count, r_en[C_SUM], 3 * ITERS, ITERS, ITERS);
    end
  endtask

  task automatic test_reset_count();
    set_seq(4'd6, 4'd6);
    op_ack = 1'b1;
    reset_after = 3;
    kick();
    run_collect(200);
    reset_after = -1;
    checks++;
    if (r_cycles !== r_fire_cycle + 1 || iter_count !== '0 || done !== 1'b1 || timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_count: exit=%0d fire=%0d iter=%0d done=%b required exit=fire+1 0 1",
               r_cycles, r_fire_cycle, iter_count, done);
    end
    reset = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_sb: %0d leftover expected entries, required 0", sb.size());
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_mul_run();
    test_class_mix();
    test_timeout();
    test_abort();
    test_start_abort();
    test_reset_count();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
- Parametrised successor to the operation-select controller.
- On `start`, repeatedly compares operands `a` and `b` (WIDTH bits) and selects one operation class: error, sum, multiply or constant.
- Drives the one-hot enable for the selected class, waits for the datapath handshake, then counts one iteration.
- Repeats until ITERS iterations complete or `abort` is asserted. The iteration counter is internal; it is no longer an external input.

Parameters:
- WIDTH, 4, operand width of `a`/`b`.
- ITERS, 8, iterations per run (>=1).
- ACK_TIMEOUT, 15, maximum EXEC cycles waiting for `op_ack`; 0 disables the timeout.
- CNT_W (localparam), $clog2(ITERS+1), width of iteration counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin run; sampled in IDLE only.
- abort  in  1  terminate run; sampled in any non-IDLE state.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- op_ack  in  1  datapath has completed the current sum/mul/const operation.
- done  out  1  high in IDLE.
- busy  out  1  high in any non-IDLE state; always equals ~done.
- sumen  out  1  sum enable.
- multien  out  1  multiply enable.
- consten  out  1  constant enable.
- erroren  out  1  error enable.
- counten  out  1  one-cycle iteration strobe.
- iter_count  out  CNT_W  iterations completed in the current or last run.
- timeout_flag  out  1  sticky: some EXEC wait hit ACK_TIMEOUT in this run.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, iter_count=0, timeout_flag=0, wait counter=0, op_sel=SUM. Outputs after reset: done=1, busy=0, all enables=0, counten=0.
- Outputs are Moore, decoded from registered state and op_sel. At most one of sumen/multien/consten/erroren is high in any cycle.
- IDLE:
  - start=1: clear iter_count and timeout_flag, go to CONTROL.
  - Otherwise stay in IDLE.
- CONTROL (1 cycle): latch op_sel from a/b sampled this cycle, checked in priority order:
  - a==0 or b==0 -> ERR
  - a<b -> MUL
  - a==b -> CONST
  - a>b -> SUM
  - Then go to EXEC.
- EXEC: assert the enable for op_sel.
  - ERR: erroren is high exactly 1 cycle, no ack needed, then go to COUNT.
  - SUM/MUL/CONST: hold the enable until op_ack=1 is sampled, then go to COUNT. op_ack sampled in the first EXEC cycle is accepted (minimum 1 cycle in EXEC). op_ack outside EXEC is ignored.
  - Timeout (ACK_TIMEOUT>0): the wait counter increments each EXEC cycle without ack. When it reaches ACK_TIMEOUT: set timeout_flag, go to COUNT (iteration still counted). Wait counter clears on entry to EXEC.
- COUNT (1 cycle): counten=1, iter_count += 1.
  - New value < ITERS -> CONTROL.
  - Otherwise -> IDLE.
- Latency:
  - start high at edge k: CONTROL after k, enable high after k+1.
  - Fastest iteration (ack in first EXEC cycle) takes 3 cycles.
  - Full run with immediate ack: 3*ITERS cycles from CONTROL entry to IDLE.
- abort=1 in CONTROL/EXEC/COUNT: next state is IDLE, enables drop next cycle. iter_count holds its completed value; no increment if aborted in COUNT. abort has priority over op_ack and timeout.
- start while busy is ignored. start and abort together in IDLE: start wins (abort is not sampled in IDLE).
- reset mid-run: returns to IDLE and clears all state the following cycle, regardless of abort/op_ack.
- Operands may change between iterations; each CONTROL re-evaluates them. iter_count never exceeds ITERS.

Optional Feature:
- Macro: OP_STATS_EN.
- Defined: adds outputs stat_sum, stat_mul, stat_const, stat_err (each CNT_W, out). Each counts EXEC entries of its class in the current run; all clear on an accepted start and on reset. Their sum equals the number of EXEC entries.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> done=1, busy=0, all enables 0, iter_count=0; start=0 for 10 cycles -> no change.
- ITERS=8, a=3, b=9, op_ack tied 1, start pulse -> multien high 8 times with one counten after each; done=1 after 24 cycles; iter_count=8; timeout_flag=0.
- Class mix: a=0,b=5 -> erroren for 1 cycle; a=6,b=6 -> consten; a=9,b=2 -> sumen. Switch operands between iterations -> enable sequence matches each CONTROL sample. With OP_STATS_EN: stat_err/const/sum match the applied counts.
- Timeout: ACK_TIMEOUT=15, a=9, b=2, op_ack=0 -> sumen high 15 cycles, then counten; timeout_flag=1 sticky until next start.
- Abort: abort=1 during 3rd iteration's EXEC -> IDLE next cycle, iter_count=2, all enables 0. A later start clears iter_count to 0.
- Collisions: start asserted while busy -> ignored. op_ack and abort in the same EXEC cycle -> abort wins, no counten. reset during COUNT -> iter_count=0 next cycle.
